// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Microprogrammed control unit for the multi-cycle CPU. It holds a micro-PC,
//   reads a control store kept in a parameter vector, and steps through it.
//   Next-address sources are: increment, two opcode dispatch tables, fetch
//   return, jump, call/return, and a conditional branch. A stall holds the
//   micro-PC and clears the state-changing control bits selected by WE_MASK.
//
//   Optional build macro: MICROCODE_CALL_EN
//     defined   : seq 101 = call (saves upc+1), seq 110 = return
//     undefined : no return register; 101 acts as jump, 110 acts as fetch (011)
//
//   Control word layout, MSB to LSB: ctrl[CTRL_W] | next[UADDR_W] | seq[3]
//     seq | meaning
//     000 | upc+1 (wraps)
//     001 | DISP1[opcode]
//     010 | DISP2[opcode]
//     011 | back to 0, instruction done
//     100 | jump to next
//     101 | call next (or jump)
//     110 | return (or fetch)
//     111 | cond ? next : upc+1
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   stall      in   hold the micro-PC
//   opcode     in   [OPC_W]   opcode for dispatch
//   cond       in   branch condition
//   ctrl       out  [CTRL_W]  datapath control word
//   upc        out  [UADDR_W] current micro-PC
//   instr_done out  one-cycle pulse on instruction completion
//   num_inst   out  [16]      completed-instruction count (wraps)
//   ucode_err  out  sticky out-of-range micro-address flag
module microcode_sequencer #(
  parameter int CTRL_W  = 16,
  parameter int UADDR_W = 4,
  parameter int DEPTH   = 16,
  parameter int OPC_W   = 4,
  parameter logic [CTRL_W-1:0] WE_MASK = '0,
  parameter logic [DEPTH*(CTRL_W+UADDR_W+3)-1:0] UCODE = '0,
  parameter logic [(2**OPC_W)*UADDR_W-1:0] DISP1 = '0,
  parameter logic [(2**OPC_W)*UADDR_W-1:0] DISP2 = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               cond,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [UADDR_W-1:0] upc,
  output logic               instr_done,
  output logic [15:0]        num_inst,
  output logic               ucode_err
);

  localparam int WORD_W = CTRL_W + UADDR_W + 3;
  localparam logic [UADDR_W:0] DEPTH_V = (UADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    SEQ_INC    = 3'b000,
    SEQ_DISP1  = 3'b001,
    SEQ_DISP2  = 3'b010,
    SEQ_FETCH  = 3'b011,
    SEQ_JUMP   = 3'b100,
    SEQ_CALL   = 3'b101,
    SEQ_RET    = 3'b110,
    SEQ_BRANCH = 3'b111
  } seq_e;

  logic [WORD_W-1:0]  word;
  logic [CTRL_W-1:0]  w_ctrl;
  logic [UADDR_W-1:0] w_next;
  seq_e               w_seq;
  logic               in_range;
  logic [UADDR_W-1:0] upc_inc;
  logic [UADDR_W-1:0] next_upc;
  logic [CTRL_W-1:0]  ctrl_raw;
  logic               done_raw;
  logic               advance;

`ifdef MICROCODE_CALL_EN
  logic [UADDR_W-1:0] ret_addr;
  logic               ret_load;
`endif

  assign in_range = ({1'b0, upc} < DEPTH_V);
  assign upc_inc  = upc + 1'b1;

  // Only words below DEPTH exist; anything else reads as zero.
  always_comb begin
    word = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (upc == UADDR_W'(k)) word = UCODE[k*WORD_W +: WORD_W];
    end
  end

  assign w_ctrl = word[WORD_W-1 -: CTRL_W];
  assign w_next = word[3 +: UADDR_W];
  assign w_seq  = seq_e'(word[2:0]);

  always_comb begin
    next_upc = upc_inc;
    ctrl_raw = '0;
    done_raw = 1'b0;
`ifdef MICROCODE_CALL_EN
    ret_load = 1'b0;
`endif
    if (!in_range) begin
      next_upc = '0;
    end else begin
      ctrl_raw = w_ctrl & ~(stall ? WE_MASK : '0);
      case (w_seq)
        SEQ_INC:    next_upc = upc_inc;
        SEQ_DISP1:  next_upc = DISP1[opcode*UADDR_W +: UADDR_W];
        SEQ_DISP2:  next_upc = DISP2[opcode*UADDR_W +: UADDR_W];
        SEQ_FETCH: begin
          next_upc = '0;
          done_raw = 1'b1;
        end
        SEQ_JUMP:   next_upc = w_next;
`ifdef MICROCODE_CALL_EN
        SEQ_CALL: begin
          next_upc = w_next;
          ret_load = 1'b1;
        end
        SEQ_RET:    next_upc = ret_addr;
`else
        SEQ_CALL:   next_upc = w_next;
        SEQ_RET: begin
          next_upc = '0;
          done_raw = 1'b1;
        end
`endif
        SEQ_BRANCH: next_upc = cond ? w_next : upc_inc;
      endcase
    end
  end

  assign advance    = ~stall;
  assign ctrl       = reset ? '0 : ctrl_raw;
  assign instr_done = done_raw & advance & ~reset;

  // An out-of-range fetch always recovers to 0, even under stall, so a
  // stalled datapath cannot pin the sequencer on a nonexistent word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc       <= '0;
      num_inst  <= '0;
      ucode_err <= 1'b0;
    end else begin
      if (!in_range) begin
        upc       <= '0;
        ucode_err <= 1'b1;
      end else if (advance) begin
        upc <= next_upc;
      end
      if (done_raw && advance) num_inst <= num_inst + 16'd1;
    end
  end

`ifdef MICROCODE_CALL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_addr <= '0;
    end else if (ret_load && advance) begin
      ret_addr <= upc_inc;
    end
  end
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

  localparam int DEPTH = 12;
  localparam logic [15:0] MASK = 16'h0800;
`ifdef MICROCODE_CALL_EN
  localparam bit CALL_EN = 1'b1;
`else
  localparam bit CALL_EN = 1'b0;
`endif

  // Program under test: ctrl / next / seq per word.
  localparam logic [15:0] PC [DEPTH] = '{16'h1001, 16'h1102, 16'h1204, 16'h1308,
                                         16'h1410, 16'h0820, 16'h0940, 16'h1780,
                                         16'h1800, 16'h1900, 16'h8A00, 16'h8B00};
  localparam logic [3:0]  PN [DEPTH] = '{4'h0, 4'h0, 4'h9, 4'h8, 4'h0, 4'h0,
                                         4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0};
  localparam logic [2:0]  PS [DEPTH] = '{3'b000, 3'b001, 3'b111, 3'b101, 3'b011, 3'b000,
                                         3'b010, 3'b100, 3'b110, 3'b011, 3'b000, 3'b000};

  localparam logic [DEPTH*23-1:0] UCODE_P = {
    PC[11], PN[11], PS[11], PC[10], PN[10], PS[10], PC[9], PN[9], PS[9],
    PC[8],  PN[8],  PS[8],  PC[7],  PN[7],  PS[7],  PC[6], PN[6], PS[6],
    PC[5],  PN[5],  PS[5],  PC[4],  PN[4],  PS[4],  PC[3], PN[3], PS[3],
    PC[2],  PN[2],  PS[2],  PC[1],  PN[1],  PS[1],  PC[0], PN[0], PS[0]};
  // DISP1[o] = o except DISP1[6] = 5; DISP2[o] = 15 - o.
  localparam logic [63:0] DISP1_P = 64'hFEDCBA98_75543210;
  localparam logic [63:0] DISP2_P = 64'h01234567_89ABCDEF;
  // Second instance: single word that completes an instruction every cycle.
  localparam logic [22:0] UCODE_W = {16'hA5A5, 4'h0, 3'b011};

  logic        clk, reset, stall, cond;
  logic [3:0]  opcode;
  logic [15:0] ctrl;
  logic [3:0]  upc;
  logic        instr_done, ucode_err;
  logic [15:0] num_inst;

  logic        rst2;
  logic [15:0] ctrl2, num_inst2;
  logic [3:0]  upc2;
  logic        instr_done2, ucode_err2;
  int          wrap_edges;

  int npass = 0;
  int nchk  = 0;

  int m_upc, m_ret, m_num;
  bit m_err;
  logic [15:0] e_ctrl;
  bit e_done, e_call;
  int e_next;

  microcode_sequencer #(
    .CTRL_W(16), .UADDR_W(4), .DEPTH(DEPTH), .OPC_W(4), .WE_MASK(MASK),
    .UCODE(UCODE_P), .DISP1(DISP1_P), .DISP2(DISP2_P)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .cond(cond),
    .ctrl(ctrl), .upc(upc), .instr_done(instr_done), .num_inst(num_inst),
    .ucode_err(ucode_err)
  );

  microcode_sequencer #(
    .CTRL_W(16), .UADDR_W(4), .DEPTH(1), .OPC_W(4), .WE_MASK(16'h0000),
    .UCODE(UCODE_W), .DISP1(64'h0), .DISP2(64'h0)
  ) u_wrap (
    .clk(clk), .reset(rst2), .stall(1'b0), .opcode(4'h0), .cond(1'b0),
    .ctrl(ctrl2), .upc(upc2), .instr_done(instr_done2), .num_inst(num_inst2),
    .ucode_err(ucode_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst2) wrap_edges <= 0;
    else      wrap_edges <= wrap_edges + 1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s: observed %h expected %h (upc model %0d)", tag, got, exp, m_upc);
  endtask

  // Reference: what the current micro-state should show and where it goes.
  task automatic predict(input bit s, input int op, input bit c);
    e_ctrl = 16'h0;
    e_done = 1'b0;
    e_call = 1'b0;
    e_next = 0;
    if (m_upc < DEPTH) begin
      e_ctrl = PC[m_upc] & (s ? ~MASK : 16'hFFFF);
      e_next = (m_upc + 1) % 16;
      case (PS[m_upc])
        3'd1: e_next = (op == 6) ? 5 : op;
        3'd2: e_next = 15 - op;
        3'd3: begin e_next = 0; e_done = !s; end
        3'd4: e_next = int'(PN[m_upc]);
        3'd5: begin e_next = int'(PN[m_upc]); e_call = CALL_EN; end
        3'd6: begin
          if (CALL_EN) e_next = m_ret;
          else begin e_next = 0; e_done = !s; end
        end
        3'd7: if (c) e_next = int'(PN[m_upc]);
        default: ;
      endcase
    end
  endtask

  task automatic apply(input bit s);
    if (m_upc >= DEPTH) begin
      m_upc = 0;
      m_err = 1'b1;
    end else if (!s) begin
      if (e_call) m_ret = (m_upc + 1) % 16;
      if (e_done) m_num = (m_num + 1) % 65536;
      m_upc = e_next;
    end
  endtask

  // Starts and ends just after a falling edge.
  task automatic cyc(input bit s, input logic [3:0] op, input bit c);
    stall = s; opcode = op; cond = c;
    #1;
    predict(s, int'(op), c);
    chk("upc", 16'(upc), 16'(m_upc));
    chk("ctrl", ctrl, e_ctrl);
    chk("instr_done", 16'(instr_done), 16'(e_done));
    chk("num_inst", num_inst, 16'(m_num));
    chk("ucode_err", 16'(ucode_err), 16'(m_err));
    @(posedge clk);
    apply(s);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit s);
    reset = 1'b1; stall = s;
    #1;
    m_upc = 0; m_ret = 0; m_num = 0; m_err = 1'b0;
    chk("rst_upc", 16'(upc), 16'h0);
    chk("rst_ctrl", ctrl, 16'h0);
    chk("rst_done", 16'(instr_done), 16'h0);
    chk("rst_num", num_inst, 16'h0);
    chk("rst_err", 16'(ucode_err), 16'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rst2 = 1'b1; stall = 1'b0; opcode = 4'h0; cond = 1'b0;
    m_upc = 0; m_ret = 0; m_num = 0; m_err = 1'b0;
    @(negedge clk);
    rst2 = 1'b0;
    do_reset(1'b0);

    // Dispatch 1 -> 5, stall three cycles at 5, then DISP2 -> 9 -> fetch.
    cyc(0, 4'h6, 0);
    cyc(0, 4'h6, 0);
    cyc(1, 4'h0, 0);
    cyc(1, 4'h3, 1);
    cyc(1, 4'h0, 0);
    cyc(0, 4'h6, 0);
    cyc(0, 4'h6, 0);
    cyc(0, 4'h0, 0);

    // Conditional branch taken, then not taken into call/return.
    cyc(0, 4'h2, 0);
    cyc(0, 4'h2, 0);
    cyc(0, 4'h0, 1);
    cyc(0, 4'h0, 0);
    cyc(0, 4'h2, 0);
    cyc(0, 4'h2, 0);
    cyc(0, 4'h0, 0);
    cyc(0, 4'h0, 0);
    cyc(0, 4'h0, 0);
    if (m_upc != 0) cyc(0, 4'h0, 0);

    // Jump to 14 (out of range), stalled there, recovers to 0 with sticky error.
    cyc(0, 4'h7, 0);
    cyc(0, 4'h7, 0);
    cyc(0, 4'h0, 0);
    cyc(1, 4'h0, 0);
    cyc(0, 4'h0, 0);
    // Increment off the end of the store: 10 -> 11 -> 12.
    cyc(0, 4'hA, 0);
    cyc(0, 4'hA, 0);
    cyc(0, 4'h0, 0);
    cyc(0, 4'h0, 0);
    cyc(0, 4'h0, 0);

    // Reset mid-instruction clears the error and restarts at 0.
    cyc(0, 4'h3, 0);
    cyc(0, 4'h3, 0);
    do_reset(1'b1);
    cyc(0, 4'h3, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0)
        do_reset(1'($urandom_range(0, 1)));
      else
        cyc(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Counter wrap on the always-completing instance.
    while (wrap_edges < 65535) @(negedge clk);
    chk("wrap_ffff", num_inst2, 16'hFFFF);
    chk("wrap_done", 16'(instr_done2), 16'h1);
    chk("wrap_ctrl", ctrl2, 16'hA5A5);
    @(negedge clk);
    chk("wrap_zero", num_inst2, 16'h0000);
    chk("wrap_err", 16'(ucode_err2), 16'h0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Parametrised microprogrammed control unit for the multi-cycle CPU.
- Replaces the fixed RT-code-to-control lookup with a full sequencer: a micro-PC register, a control store held in a parameter vector, two opcode dispatch tables, a conditional branch and a stall hold.
- Sits between the instruction register (opcode) and the datapath control inputs.

Parameters:
- CTRL_W, 16, width of the control word driven to the datapath.
- UADDR_W, 4, micro-address width.
- DEPTH, 16, number of valid control-store words; must be at most 2**UADDR_W.
- OPC_W, 4, opcode width; each dispatch table has 2**OPC_W entries.
- WE_MASK, {CTRL_W{1'b0}}, set bits mark state-changing controls that are forced to 0 while stall=1.
- UCODE, all zero, control store of DEPTH words, each WORD_W = CTRL_W+UADDR_W+3 bits. Word k occupies [k*WORD_W +: WORD_W]. Layout per word, MSB to LSB: ctrl, next, seq[2:0].
- DISP1, all zero, first dispatch table. Entry o occupies [o*UADDR_W +: UADDR_W].
- DISP2, all zero, second dispatch table. Same packing as DISP1.

Ports:
- clk, in, 1, clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- stall, in, 1, hold the micro-PC (for example during a memory wait).
- opcode, in, OPC_W, current instruction opcode, used by dispatch.
- cond, in, 1, branch condition from the ALU or datapath.
- ctrl, out, CTRL_W, control word for the current micro-state.
- upc, out, UADDR_W, current micro-PC.
- instr_done, out, 1, one-cycle pulse when an instruction completes.
- num_inst, out, 16, count of completed instructions.
- ucode_err, out, 1, sticky flag set when an out-of-range micro-address is fetched.

Behaviour:
- Reset values (asynchronous, immediate): upc=0, num_inst=0, ucode_err=0, return register=0. While reset=1: ctrl=0 and instr_done=0.
- Control-store read is combinational. The word is W = UCODE[upc].
- ctrl = W.ctrl & ~(stall ? WE_MASK : 0).
- Next micro-PC is selected by W.seq:
  - 000: upc+1, wrapping modulo 2**UADDR_W.
  - 001: DISP1[opcode].
  - 010: DISP2[opcode].
  - 011: 0 (return to fetch); instr_done=1 this cycle.
  - 100: W.next (unconditional jump).
  - 101: call. Return register <= upc+1, upc <= W.next.
  - 110: return. upc <= return register.
  - 111: cond ? W.next : upc+1.
- Update rule: upc loads next-PC on each rising edge with stall=0.
- While stall=1:
  - upc, the return register and num_inst hold.
  - instr_done=0.
  - ctrl still shows W.ctrl with WE_MASK bits cleared.
- One micro-state per cycle. Latency from dispatch to the target word appearing on ctrl is exactly 1 cycle.
- num_inst increments by 1 on each edge where instr_done=1 and wraps from 0xFFFF to 0.
- Out-of-range micro-address (upc >= DEPTH):
  - ctrl=0 and instr_done=0.
  - Next upc=0, regardless of stall.
  - ucode_err<=1 and stays set until reset.
- Reset asserted mid-instruction: state is abandoned and execution restarts at micro-address 0 on the first edge after release.
- Single-level return register: a second call overwrites the saved address. A return with no prior call goes to 0.

Optional Feature:
- Macro: MICROCODE_CALL_EN.
- Defined: seq 101 and 110 behave as call and return, as above.
- Undefined:
  - No return register is synthesised.
  - 101 behaves as 100 (jump to W.next).
  - 110 behaves as 011 (go to 0 and pulse instr_done).

Test Plan:
Common setup for all tests: CTRL_W=16, UADDR_W=4, DEPTH=12.
- Reset and sequential run: hold reset=1, then release with word0.seq=000 and word1.seq=011. Expected: upc goes 0, 1, 0. instr_done pulses in the cycle where upc=1. num_inst reads 1.
- Dispatch: word1.seq=001, DISP1[4'h6]=4'h5, opcode=6. Expected: upc=5 one cycle after upc=1. ctrl equals UCODE[5].ctrl.
- Stall with mask: WE_MASK=16'h0800 and word5.ctrl=16'h0820. Assert stall for 3 cycles at upc=5. Expected: upc holds at 5, ctrl=16'h0020, instr_done=0, num_inst unchanged. After release, upc advances.
- Conditional branch: word2 has seq=111 and next=9. With cond=1 → upc=9. With cond=0 → upc=3.
- Call and return (MICROCODE_CALL_EN defined): word3 has seq=101 and next=8; word8 has seq=110. Expected: upc goes 3, 8, 4. Rebuild without the macro: upc goes 3, 8, 0, with instr_done pulsing at upc=8.
- Out-of-range and wrap:
  - A jump to address 14: ctrl=0 for that cycle, then upc=0, and ucode_err stays 1 until reset.
  - Preloaded case: bring num_inst to 16'hFFFF, then complete one instruction. Expected: num_inst=0.
